mobius_seq: RTL and testbench
=============================

# mobius_seq

Iterative controller and datapath for the binary Möbius transform over GF(2). It accepts an N-bit vector through a valid/ready handshake and holds it in a working register. It then applies the log2(N) butterfly stages, S stages per clock, under a stage counter, and presents the result through a second valid/ready handshake. It replaces the fully unrolled log2(N)-stage combinational network where area matters more than latency.

## Interface
- N, default 8192: vector width; must equal 2**LOG2_N.
- LOG2_N, default 13: number of butterfly stages.
- S, default 1: stages applied per clock; must divide LOG2_N. Any violated parameter rule is an elaboration error.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high; clears all state.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a vector.
- in_data  input  [0:N-1]  input vector; bit 0 is element index 0.
- out_valid  output  1  out_data holds a completed transform.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  [0:N-1]  transformed vector, driven directly from the working register.
- abort  input  1  synchronous; discards any job in flight.
- busy  output  1  high while in RUN.

## Operation
- Stage s (0 ≤ s < LOG2_N):
  - half = N >> (s+1).
  - For every block base = k·2·half and every j < half: r[base+j+half] ← r[base+j+half] ^ r[base+j].
  - r[base+j] is unchanged.
- One RUN cycle applies stages cnt … cnt+S-1 in ascending order, as a chain of combinational stages, then advances cnt by S.
- Result: out[i] = XOR of in[m] over all m whose bit pattern is a subset of i's. The transform is its own inverse.
- FSM states and transitions:
  - IDLE: in_ready=1. When in_valid is high, r ← in_data, cnt ← 0, go to RUN.
  - RUN: apply S stages. If cnt+S == LOG2_N, go to DONE; otherwise stay in RUN.
  - DONE: out_valid=1, r frozen. When out_ready is high, go to IDLE.
- in_ready is high only in IDLE. A vector cannot be accepted in the same cycle a result is handed off.
- abort:
  - In any state, the next edge goes to IDLE and cnt is cleared. r is not cleared.
  - abort has priority over every other transition, including a simultaneous accept or hand-off; neither of those takes effect.
- cnt width is clog2(LOG2_N+1). The counter never wraps: it is reloaded on accept.
- out_data is undefined unless out_valid=1. It reflects r at all times.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, out_data=0 (r cleared), state=IDLE, cnt=0.
- Asserting rst mid-RUN or in DONE drops the job immediately, without waiting for a clock edge.
- Latency:
  - Accept at edge t0 → busy high for L = LOG2_N/S cycles.
  - out_valid rises after edge t0+L.
- Hand-off: out_valid stays high with stable out_data until the edge where out_ready=1. It drops after that edge and in_ready rises.
- Throughput: with out_ready held high, one vector per L+2 cycles.
- out_ready in IDLE or RUN has no effect. in_valid outside IDLE is ignored; the data is not captured.
- Critical path: S XOR levels plus the stage-select mux. The select is indexed by cnt and covers LOG2_N/S stage groups.

## Test plan
- N=8, S=1, in_data = 1000_0000 (element 0 set) → out_data = 1111_1111. out_valid rises exactly 3 cycles after the accept edge.
- N=8, S=1, in_data = 1111_1111 → out_data = 1000_0000. in_data = 0000_0001 → out_data = 0000_0001.
- Involution: N=16, S=2, random vector x. Feed x, then feed the result back → final out_data == x. Check latency is 2 cycles per job.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_valid and out_data stable, in_ready=0, in_valid pulses ignored. Raise out_ready → IDLE next cycle, then the next vector is accepted.
- abort asserted in the 2nd RUN cycle (N=8, S=1) → IDLE after the next edge, out_valid never asserts. A following vector produces the correct result.
- Async reset pulsed mid-RUN, between clock edges → outputs reach reset values without a clock edge. Operation resumes normally after rst deasserts.

Source files
------------

// File: rtl/mobius_seq_if.sv
// Valid/ready handshake bundle for mobius_seq: input vector channel and result channel.
// The block side uses the slave modport; the producer/consumer side uses master.
interface mobius_seq_if #(
  parameter int N = 8192
);
  logic         in_valid;
  logic         in_ready;
  logic [0:N-1] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [0:N-1] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/mobius_seq.sv
// Iterative binary Moebius transform over GF(2): one working register, S butterfly
// stages per clock under a stage counter, valid/ready on both sides.
module mobius_seq #(
  parameter int N      = 8192,
  parameter int LOG2_N = 13,
  parameter int S      = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         abort,
  output logic         busy,
  mobius_seq_if.slave  bus
);
  localparam int GROUPS = LOG2_N / S;
  localparam int CNT_W  = $clog2(LOG2_N + 1);
  localparam logic [CNT_W-1:0] CNT_STEP = CNT_W'(S);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOG2_N - S);

  if (N != (1 << LOG2_N) || S < 1 || (LOG2_N % S) != 0) begin : g_bad_params
    $error("mobius_seq: N must be 2**LOG2_N and S must divide LOG2_N");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [0:N-1]       r;
  logic [0:N-1]       next_r;
  logic               in_ready_q;
  logic               out_valid_q;
  logic [GROUPS-1:0][0:N-1] grp_out;

  // One butterfly stage: every element in the upper half of a block absorbs its partner.
  function automatic logic [0:N-1] stage_xor(input logic [0:N-1] v, input int s);
    logic [0:N-1] res;
    int           half;
    half = N >> (s + 1);
    res  = v;
    for (int i = 0; i < N; i++) begin
      if ((i & half) != 0) res[i] = v[i] ^ v[i - half];
    end
    return res;
  endfunction

  // Each group is a fixed chain of S stages; cnt picks which group feeds r.
  for (genvar g = 0; g < GROUPS; g++) begin : g_grp
    logic [0:N-1] chain;
    always_comb begin
      chain = r;
      for (int p = 0; p < S; p++) chain = stage_xor(chain, g * S + p);
    end
    assign grp_out[g] = chain;
  end

  always_comb begin
    // NOTE: default assignment first so no path through this block leaves next_r unassigned (no latch).
    next_r = r;
    for (int g = 0; g < GROUPS; g++) begin
      if (cnt == CNT_W'(g * S)) next_r = grp_out[g];
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      // NOTE: the wide working register is reset on purpose so out_data reads zero after reset.
      r           <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
    end else if (abort) begin
      // Abort beats accept and hand-off; r keeps whatever it held.
      state       <= IDLE;
      cnt         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            r          <= bus.in_data;
            cnt        <= '0;
            state      <= RUN;
            in_ready_q <= 1'b0;
            busy       <= 1'b1;
          end
        end
        RUN: begin
          r   <= next_r;
          cnt <= cnt + CNT_STEP;
          if (cnt == CNT_LAST) begin
            state       <= DONE;
            busy        <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          cnt         <= '0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = r;
endmodule

// File: tb/tb_mobius_seq.sv
// Bench for mobius_seq: two instances (N=8,S=1 and N=16,S=2) checked every cycle against a
// subset-XOR reference and a job-age handshake model, plus directed and randomized traffic.
module tb_mobius_seq;
  localparam int NA = 8;
  localparam int LAT_A = 3;
  localparam int NB = 16;
  localparam int LAT_B = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic abort_a = 1'b0;
  logic abort_b = 1'b0;
  logic busy_a, busy_b;

  mobius_seq_if #(.N(NA)) bus_a ();
  mobius_seq_if #(.N(NB)) bus_b ();

  mobius_seq #(.N(NA), .LOG2_N(3), .S(1)) dut_a (
    .clk(clk), .rst(rst), .abort(abort_a), .busy(busy_a), .bus(bus_a.slave)
  );
  mobius_seq #(.N(NB), .LOG2_N(4), .S(2)) dut_b (
    .clk(clk), .rst(rst), .abort(abort_b), .busy(busy_b), .bus(bus_b.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // out[i] = XOR of x[m] over every m whose index bits are a subset of i's.
  function automatic logic [0:15] mobius_ref(input logic [0:15] x, input int n);
    logic [0:15] y;
    logic        acc;
    y = '0;
    for (int i = 0; i < n; i++) begin
      acc = 1'b0;
      for (int m = 0; m < n; m++) begin
        if ((m & ~i) == 0) acc ^= x[m];
      end
      y[i] = acc;
    end
    return y;
  endfunction

  // A job is just "pending" plus its age in cycles since accept.
  typedef struct {
    bit          pending;
    int          age;
    logic [0:15] exp;
  } job_t;

  job_t ma = '{pending: 1'b0, age: 0, exp: '0};
  job_t mb = '{pending: 1'b0, age: 0, exp: '0};

  task automatic model_step(inout job_t m, input bit iv, input logic [0:15] d,
                            input bit ordy, input bit ab, input int n, input int lat);
    if (ab) m.pending = 1'b0;
    else if (!m.pending) begin
      if (iv) begin
        m.pending = 1'b1;
        m.age     = 0;
        m.exp     = mobius_ref(d, n);
      end
    end else if (m.age < lat) m.age++;
    else if (ordy) m.pending = 1'b0;
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma.pending = 1'b0;
      mb.pending = 1'b0;
    end else begin
      model_step(ma, bus_a.in_valid, {bus_a.in_data, 8'h00}, bus_a.out_ready, abort_a, NA, LAT_A);
      model_step(mb, bus_b.in_valid, bus_b.in_data, bus_b.out_ready, abort_b, NB, LAT_B);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("a.in_ready", 32'(bus_a.in_ready), 32'(!ma.pending));
      check("a.out_valid", 32'(bus_a.out_valid), 32'(ma.pending && ma.age == LAT_A));
      check("a.busy", 32'(busy_a), 32'(ma.pending && ma.age < LAT_A));
      if (ma.pending && ma.age == LAT_A) check("a.out_data", 32'(bus_a.out_data), 32'(ma.exp[0:7]));
      check("b.in_ready", 32'(bus_b.in_ready), 32'(!mb.pending));
      check("b.out_valid", 32'(bus_b.out_valid), 32'(mb.pending && mb.age == LAT_B));
      check("b.busy", 32'(busy_b), 32'(mb.pending && mb.age < LAT_B));
      if (mb.pending && mb.age == LAT_B) check("b.out_data", 32'(bus_b.out_data), 32'(mb.exp));
    end
  end

  task automatic job_a(input logic [0:7] d, output logic [0:7] res, output int lat);
    int guard = 0;
    while (!bus_a.in_ready && guard < 50) begin @(posedge clk); #2; guard++; end
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = d;
    @(posedge clk); #2;
    bus_a.in_valid = 1'b0;
    bus_a.in_data  = 8'($urandom);
    lat = 0;
    while (!bus_a.out_valid && lat < 50) begin @(posedge clk); #2; lat++; end
    res = bus_a.out_data;
    bus_a.out_ready = 1'b1;
    @(posedge clk); #2;
    bus_a.out_ready = 1'b0;
  endtask

  task automatic job_b(input logic [0:15] d, output logic [0:15] res, output int lat);
    int guard = 0;
    while (!bus_b.in_ready && guard < 50) begin @(posedge clk); #2; guard++; end
    bus_b.in_valid = 1'b1;
    bus_b.in_data  = d;
    @(posedge clk); #2;
    bus_b.in_valid = 1'b0;
    bus_b.in_data  = 16'($urandom);
    lat = 0;
    while (!bus_b.out_valid && lat < 50) begin @(posedge clk); #2; lat++; end
    res = bus_b.out_data;
    bus_b.out_ready = 1'b1;
    @(posedge clk); #2;
    bus_b.out_ready = 1'b0;
  endtask

  initial begin
    logic [0:7]  ra, d8, held;
    logic [0:15] x, y, z, ref16;
    int          lat, lat2, guard;

    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b0;
    #1 rst = 1'b1;
    #11 rst = 1'b0;

    check("rst.a.in_ready", 32'(bus_a.in_ready), 32'd1);
    check("rst.a.out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst.a.busy", 32'(busy_a), 32'd0);
    check("rst.a.out_data", 32'(bus_a.out_data), 32'd0);
    check("rst.b.out_data", 32'(bus_b.out_data), 32'd0);

    // Pin the reference itself on known vectors.
    ref16 = mobius_ref(16'hFF00, 8);
    check("ref.ones", 32'(ref16), 32'h8000);
    ref16 = mobius_ref(16'h8000, 8);
    check("ref.unit", 32'(ref16), 32'hFF00);

    @(posedge clk); #2;

    job_a(8'b1000_0000, ra, lat);
    check("t.unit.out", 32'(ra), 32'hFF);
    check("t.unit.lat", 32'(lat), 32'd3);
    job_a(8'b1111_1111, ra, lat);
    check("t.ones.out", 32'(ra), 32'h80);
    job_a(8'b0000_0001, ra, lat);
    check("t.last.out", 32'(ra), 32'h01);

    // Involution on the N=16, S=2 instance.
    x = 16'($urandom);
    job_b(x, y, lat);
    ref16 = mobius_ref(x, 16);
    check("inv.first", 32'(y), 32'(ref16));
    check("inv.lat1", 32'(lat), 32'd2);
    job_b(y, z, lat2);
    check("inv.back", 32'(z), 32'(x));
    check("inv.lat2", 32'(lat2), 32'd2);

    // Backpressure: result must hold while out_ready stays low; in_valid is ignored.
    bus_a.in_valid = 1'b1; bus_a.in_data = 8'hA5;
    @(posedge clk); #2;
    bus_a.in_valid = 1'b0;
    guard = 0;
    while (!bus_a.out_valid && guard < 50) begin @(posedge clk); #2; guard++; end
    check("bp.reached", 32'(bus_a.out_valid), 32'd1);
    held = bus_a.out_data;
    for (int k = 0; k < 5; k++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_data  = 8'($urandom);
      @(posedge clk); #2;
      check("bp.out_valid", 32'(bus_a.out_valid), 32'd1);
      check("bp.out_data", 32'(bus_a.out_data), 32'(held));
      check("bp.in_ready", 32'(bus_a.in_ready), 32'd0);
    end
    bus_a.out_ready = 1'b1;
    @(posedge clk); #2;
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b0;
    check("bp.release.in_ready", 32'(bus_a.in_ready), 32'd1);
    check("bp.release.out_valid", 32'(bus_a.out_valid), 32'd0);
    job_a(8'h3C, ra, lat);
    ref16 = mobius_ref({8'h3C, 8'h00}, 8);
    check("bp.next", 32'(ra), 32'(ref16[0:7]));

    // Abort in the second RUN cycle.
    bus_a.in_valid = 1'b1; bus_a.in_data = 8'h5A;
    @(posedge clk); #2;
    bus_a.in_valid = 1'b0;
    @(posedge clk); #2;
    abort_a = 1'b1;
    @(posedge clk); #2;
    abort_a = 1'b0;
    check("abort.in_ready", 32'(bus_a.in_ready), 32'd1);
    check("abort.busy", 32'(busy_a), 32'd0);
    for (int k = 0; k < 6; k++) begin
      check("abort.out_valid", 32'(bus_a.out_valid), 32'd0);
      @(posedge clk); #2;
    end
    d8 = 8'($urandom);
    job_a(d8, ra, lat);
    ref16 = mobius_ref({d8, 8'h00}, 8);
    check("abort.next", 32'(ra), 32'(ref16[0:7]));

    // Asynchronous reset between clock edges, mid-RUN.
    bus_a.in_valid = 1'b1; bus_a.in_data = 8'hC3;
    @(posedge clk); #2;
    bus_a.in_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("arst.in_ready", 32'(bus_a.in_ready), 32'd1);
    check("arst.out_valid", 32'(bus_a.out_valid), 32'd0);
    check("arst.busy", 32'(busy_a), 32'd0);
    check("arst.out_data", 32'(bus_a.out_data), 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #2;
    job_a(8'b1000_0000, ra, lat);
    check("arst.resume", 32'(ra), 32'hFF);
    check("arst.resume.lat", 32'(lat), 32'd3);

    // Random traffic on both instances; the per-cycle compare does the checking.
    for (int c = 0; c < 800; c++) begin
      bus_a.in_valid  = 1'($urandom_range(0, 1));
      bus_a.in_data   = 8'($urandom);
      bus_a.out_ready = ($urandom_range(0, 3) != 0);
      abort_a         = ($urandom_range(0, 19) == 0);
      bus_b.in_valid  = 1'($urandom_range(0, 1));
      bus_b.in_data   = 16'($urandom);
      bus_b.out_ready = ($urandom_range(0, 3) != 0);
      abort_b         = ($urandom_range(0, 19) == 0);
      @(posedge clk); #2;
    end
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0; abort_a = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0; abort_b = 1'b0;
    repeat (3) @(posedge clk);
    #2;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
